// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, LSB first, W RUN cycles per sum.
// Define SERADD_COUT_EN to expose the registered final carry on cout.
//   state | meaning
//   IDLE  | ready, waiting for start
//   RUN   | one sum bit per cycle
//   DONE  | one-cycle done pulse, s/cout final
module serial_add_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clr,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s
`ifdef SERADD_COUT_EN
  ,
  output logic         cout
`endif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_reg, b_reg;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           load, step, last;
  logic           fa_sum, fa_cy;

  assign last   = (cnt == CW'(W - 1));
  assign fa_sum = a_reg[0] ^ b_reg[0] ^ carry;
  assign fa_cy  = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && !clr) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = !clr;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Sum bits refill operand A from the MSB side, so A ends up holding the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
`ifdef SERADD_COUT_EN
      cout  <= 1'b0;
`endif
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      a_reg <= x;
      b_reg <= y;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (step) begin
      a_reg <= {fa_sum, a_reg[W-1:1]};
      b_reg <= {1'b0, b_reg[W-1:1]};
      carry <= fa_cy;
      if (last) begin
        cnt  <= '0;
        s    <= {fa_sum, a_reg[W-1:1]};
`ifdef SERADD_COUT_EN
        cout <= fa_cy;
`endif
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: cycle-level reference model feeds an expected-result
// queue; a negedge monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         ready, busy, done;
  logic [W-1:0] s;
`ifdef SERADD_COUT_EN
  logic         cout;
`endif

  serial_add_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .x(x), .y(y),
    .ready(ready), .busy(busy), .done(done), .s(s)
`ifdef SERADD_COUT_EN
    , .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cy;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_left = 0;   // cycles until model is back in IDLE
  logic [W-1:0] m_s_last = '0;
  logic         m_cy_last = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted start occupies W RUN cycles plus one DONE cycle
  always @(posedge clk) begin
    logic [W:0] t;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      m_left = 0;
      q.delete();
    end else if (clr) begin
      if (m_left >= 2) void'(q.pop_back());
      m_left = 0;
    end else if (m_left == 0) begin
      if (start) begin
        t = {1'b0, x} + {1'b0, y};
        e.sum = t[W-1:0];
        e.cy  = t[W];
        e.acc = cyc;
        q.push_back(e);
        m_left = W + 1;
      end
    end else begin
      m_left--;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(s), 32'(e.sum));
        chk("latency", cyc - e.acc, W);
`ifdef SERADD_COUT_EN
        chk("cout", 32'(cout), 32'(e.cy));
`endif
        m_s_last  = e.sum;
        m_cy_last = e.cy;
      end
    end
    chk("ready", 32'(ready), 32'(m_left == 0));
    chk("busy", 32'(busy), 32'(m_left >= 2));
    chk("done", 32'(done), 32'(m_left == 1));
    if (m_left == 0) begin
      chk("s_hold", 32'(s), 32'(m_s_last));
`ifdef SERADD_COUT_EN
      chk("cout_hold", 32'(cout), 32'(m_cy_last));
`endif
    end
  end

  task automatic wait_idle(input int lim);
    int n = 0;
    while (m_left != 0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_left != 0) chk("idle_timeout", 1, 0);
  endtask

  task automatic op(input logic [W-1:0] xv, input logic [W-1:0] yv);
    wait_idle(50);
    start = 1'b1; x = xv; y = yv;
    @(posedge clk); #1;
    start = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s", 32'(s), 0);
    rst_n = 1'b1;

    op(4'd3, 4'd5);
    op(4'd15, 4'd1);
    op(4'd15, 4'd15);
    op(4'd0, 4'd0);

    // start during RUN must be ignored
    op(4'd2, 4'd2);
    @(posedge clk); #1;
    start = 1'b1; x = 4'd7; y = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(50);

    // clr in the second RUN cycle abandons the sum
    op(4'd9, 4'd4);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_ready", 32'(ready), 1);
    chk("clr_s_kept", 32'(s), 4);
    op(4'd1, 4'd1);
    wait_idle(50);

    // clr beats start in IDLE
    start = 1'b1; clr = 1'b1; x = 4'd5; y = 4'd6;
    @(posedge clk); #1;
    chk("clr_start_ready", 32'(ready), 1);
    start = 1'b0; clr = 1'b0;

    // asynchronous reset mid-RUN, release with start held
    op(4'd6, 4'd7);
    @(posedge clk); #3;
    rst_n = 1'b0;
    m_left = 0;
    q.delete();
    m_s_last = '0;
    m_cy_last = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_s", 32'(s), 0);
    start = 1'b1; x = 4'd6; y = 4'd5;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_accept", 32'(busy), 1);
    start = 1'b0;
    wait_idle(50);

    // back-to-back with start held and operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle(50);

    // random traffic with occasional clr
    for (int i = 0; i < 1500; i++) begin
      start = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 19) == 0);
      x = W'($urandom);
      y = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; clr = 1'b0;
    wait_idle(50);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
